// File: rtl/quad_decoder_mc.sv
// -----------------------------------------------------------------------------
// quad_decoder_mc
//   Quadrature encoder decoder for the motor-control PID path. One A/B pair per
//   instance: input synchronisers, per-input glitch filter, x1/x2/x4 decoding,
//   sticky illegal-transition flag and step-period measurement.
//
//   Optional feature (macro QDEC_INDEX_EN): index input with its own
//   synchroniser/filter chain, latching the counter on a filtered rising edge.
//
// Parameters
//   CW   position counter width
//   SYNC synchroniser flops per input (>= 2)
//   FILT cycles a new level must persist before acceptance (1 = no filtering)
//   PW   period measurement width
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   A, B              encoder phases (asynchronous)
//   mode              00 x4, 01 x2, 10 x1, 11 x4
//   clear             synchronous counter clear (wins over a step)
//   err_clr           clears sticky err (a simultaneous illegal move wins)
//   counter           signed position, wraps modulo 2^CW
//   dir               last counted direction (1 = up)
//   step              one-cycle pulse per counted step
//   err               sticky illegal-transition flag
//   period            cycles between the last two counted steps
//   period_valid      a complete period has been measured
//   index             (QDEC_INDEX_EN) index pulse
//   index_pos         (QDEC_INDEX_EN) counter latched on index rising edge
//   index_seen        (QDEC_INDEX_EN) sticky index-edge flag
// -----------------------------------------------------------------------------
module quad_decoder_mc #(
  parameter int CW   = 24,
  parameter int SYNC = 3,
  parameter int FILT = 4,
  parameter int PW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          A,
  input  logic          B,
  input  logic [1:0]    mode,
  input  logic          clear,
  input  logic          err_clr,
  output logic [CW-1:0] counter,
  output logic          dir,
  output logic          step,
  output logic          err,
  output logic [PW-1:0] period,
  output logic          period_valid
`ifdef QDEC_INDEX_EN
  ,
  input  logic          index,
  output logic [CW-1:0] index_pos,
  output logic          index_seen
`endif
);

`ifdef QDEC_INDEX_EN
  localparam int NIN = 3;
`else
  localparam int NIN = 2;
`endif
  localparam int FCW = $clog2(FILT + 1);

  // Input bit map: 0 = A, 1 = B, 2 = index (when present)
  logic [NIN-1:0] pins;
`ifdef QDEC_INDEX_EN
  assign pins = {index, B, A};
`else
  assign pins = {B, A};
`endif

  logic [NIN-1:0][SYNC-1:0] sync_q, sync_d;
  logic [NIN-1:0]           filt_q, filt_d;
  logic [NIN-1:0][FCW-1:0]  fcnt_q, fcnt_d;

  logic [1:0]    ab_cur_q, ab_cur_d;
  logic [1:0]    ab_prev_q, ab_prev_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          dir_q, dir_d;
  logic          step_q, step_d;
  logic          err_q, err_d;
  logic [PW-1:0] run_q, run_d;
  logic [PW-1:0] period_q, period_d;
  logic          pvalid_q, pvalid_d;
  logic          first_q, first_d;

  logic [1:0] chg;
  logic [1:0] pos_delta;
  logic       illegal;
  logic       cnt_up;
  logic       cnt_dn;

  // Quadrature phase position of an {A,B} pair along the up sequence
  function automatic logic [1:0] quad_pos(input logic [1:0] ab);
    logic [1:0] p;
    case (ab)
      2'b00:   p = 2'd0;
      2'b10:   p = 2'd1;
      2'b11:   p = 2'd2;
      2'b01:   p = 2'd3;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

  // Synchroniser shift and glitch filter per input
  always_comb begin
    sync_d = sync_q;
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < NIN; i++) begin
      sync_d[i] = {sync_q[i][SYNC-2:0], pins[i]};
      if (sync_q[i][SYNC-1] != filt_q[i]) begin
        // Accept on the edge where the difference has lasted FILT cycles
        if (fcnt_q[i] == FCW'(FILT - 1)) begin
          filt_d[i] = sync_q[i][SYNC-1];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + FCW'(1);
        end
      end else begin
        fcnt_d[i] = '0;
      end
    end
  end

  // Decode: registered current/previous filtered AB, mode gating
  always_comb begin
    ab_cur_d  = {filt_q[0], filt_q[1]};
    ab_prev_d = ab_cur_q;
    chg       = ab_prev_q ^ ab_cur_q;
    illegal   = &chg;
    pos_delta = quad_pos(ab_cur_q) - quad_pos(ab_prev_q);
    cnt_up    = 1'b0;
    cnt_dn    = 1'b0;
    case (mode)
      2'b01: begin
        // x2: only transitions where A moved
        cnt_up = (pos_delta == 2'd1) && chg[1];
        cnt_dn = (pos_delta == 2'd3) && chg[1];
      end
      2'b10: begin
        // x1: single edge of the cycle in each direction
        cnt_up = (ab_prev_q == 2'b00) && (ab_cur_q == 2'b10);
        cnt_dn = (ab_prev_q == 2'b10) && (ab_cur_q == 2'b00);
      end
      default: begin
        cnt_up = (pos_delta == 2'd1);
        cnt_dn = (pos_delta == 2'd3);
      end
    endcase
  end

  // Counter, direction, step pulse and sticky error
  always_comb begin
    step_d = cnt_up | cnt_dn;
    if (cnt_up) begin
      counter_d = counter_q + CW'(1);
      dir_d     = 1'b1;
    end else if (cnt_dn) begin
      counter_d = counter_q - CW'(1);
      dir_d     = 1'b0;
    end else begin
      counter_d = counter_q;
      dir_d     = dir_q;
    end
    if (clear) begin
      counter_d = '0;
    end else begin
      counter_d = counter_d;
    end
    if (illegal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Step-period measurement with standstill saturation
  always_comb begin
    run_d    = run_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    first_d  = first_q;
    if (step_d) begin
      run_d   = PW'(1);
      first_d = 1'b1;
      // The first step after reset only restarts the running count
      if (first_q) begin
        period_d = run_q;
        pvalid_d = 1'b1;
      end else begin
        period_d = period_q;
      end
    end else if (run_q != {PW{1'b1}}) begin
      run_d = run_q + PW'(1);
    end else begin
      run_d    = run_q;
      period_d = {PW{1'b1}};
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      filt_q    <= '0;
      fcnt_q    <= '0;
      ab_cur_q  <= 2'b00;
      ab_prev_q <= 2'b00;
      counter_q <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      run_q     <= PW'(1);
      period_q  <= {PW{1'b1}};
      pvalid_q  <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      ab_cur_q  <= ab_cur_d;
      ab_prev_q <= ab_prev_d;
      counter_q <= counter_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
      run_q     <= run_d;
      period_q  <= period_d;
      pvalid_q  <= pvalid_d;
      first_q   <= first_d;
    end
  end

  assign counter      = counter_q;
  assign dir          = dir_q;
  assign step         = step_q;
  assign err          = err_q;
  assign period       = period_q;
  assign period_valid = pvalid_q;

`ifdef QDEC_INDEX_EN
  logic          idx_prev_q, idx_prev_d;
  logic [CW-1:0] index_pos_q, index_pos_d;
  logic          index_seen_q, index_seen_d;

  // Index edge detect; latches the post-update counter of that cycle
  always_comb begin
    idx_prev_d = filt_q[2];
    if (filt_q[2] && !idx_prev_q) begin
      index_pos_d  = counter_d;
      index_seen_d = 1'b1;
    end else begin
      index_pos_d  = index_pos_q;
      index_seen_d = index_seen_q;
    end
  end

  // Index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_prev_q   <= 1'b0;
      index_pos_q  <= '0;
      index_seen_q <= 1'b0;
    end else begin
      idx_prev_q   <= idx_prev_d;
      index_pos_q  <= index_pos_d;
      index_seen_q <= index_seen_d;
    end
  end

  assign index_pos  = index_pos_q;
  assign index_seen = index_seen_q;
`endif

endmodule

// File: tb/tb_quad_decoder_mc.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder_mc
//   Self-checking bench for quad_decoder_mc (default parameters). Directed
//   steps followed by a random walk checked against a phase-position model.
// -----------------------------------------------------------------------------
module tb_quad_decoder_mc;

  localparam int CW   = 24;
  localparam int SYNC = 3;
  localparam int FILT = 4;
  localparam int PW   = 16;
  localparam int LAT  = SYNC + FILT + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          A, B;
  logic [1:0]    mode;
  logic          clear, err_clr;
  logic [CW-1:0] counter;
  logic          dir, step, err;
  logic [PW-1:0] period;
  logic          period_valid;
`ifdef QDEC_INDEX_EN
  logic          index;
  logic [CW-1:0] index_pos;
  logic          index_seen;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [1:0]    model_ab  = 2'b00;
  logic [CW-1:0] model_cnt = '0;
  logic          model_dir = 1'b0;
  logic          model_err = 1'b0;

  always #5 clk = ~clk;

  quad_decoder_mc #(.CW(CW), .SYNC(SYNC), .FILT(FILT), .PW(PW)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .mode(mode), .clear(clear),
    .err_clr(err_clr), .counter(counter), .dir(dir), .step(step), .err(err),
    .period(period), .period_valid(period_valid)
`ifdef QDEC_INDEX_EN
    , .index(index), .index_pos(index_pos), .index_seen(index_seen)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Position of an {A,B} pair along the up sequence 00,10,11,01
  function automatic int qpos(input logic [1:0] ab);
    return (ab == 2'b00) ? 0 : (ab == 2'b10) ? 1 : (ab == 2'b11) ? 2 : 3;
  endfunction

  // Model: what the decoder should do for a settled pin move
  task automatic model_move(input logic [1:0] ab);
    int d;
    int s;
    bit counted;
    d = (qpos(ab) - qpos(model_ab) + 4) % 4;
    if (d == 2) begin
      model_err = 1'b1;
    end else if (d != 0) begin
      s = (d == 1) ? 1 : -1;
      counted = 1'b1;
      if (mode == 2'b01 && ab[1] == model_ab[1]) counted = 1'b0;
      if (mode == 2'b10 && !((model_ab == 2'b00 && ab == 2'b10) ||
                             (model_ab == 2'b10 && ab == 2'b00))) counted = 1'b0;
      if (counted) begin
        model_cnt = model_cnt + CW'(s);
        model_dir = (s == 1);
      end
    end
    model_ab = ab;
  endtask

  task automatic set_pins(input logic [1:0] ab);
    model_move(ab);
    A = ab[1];
    B = ab[0];
  endtask

  task automatic move(input logic [1:0] ab, input int hold);
    set_pins(ab);
    repeat (hold) @(negedge clk);
  endtask

  // Move and measure step latency (edges after the first sampling edge) and pulses
  task automatic move_timed(input logic [1:0] ab);
    int lat;
    int pulses;
    lat = -1;
    pulses = 0;
    set_pins(ab);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k - 1;
      end
    end
    chk("step_latency", 64'(lat), 64'(LAT));
    chk("step_pulses", 64'(pulses), 64'd1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_cnt = '0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [1:0] nab;
    reset = 1'b1; A = 1'b0; B = 1'b0; mode = 2'b00; clear = 1'b0; err_clr = 1'b0;
`ifdef QDEC_INDEX_EN
    index = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_counter", counter, 64'd0);
    chk("rst_dir", dir, 64'd0);
    chk("rst_step", step, 64'd0);
    chk("rst_err", err, 64'd0);
    chk("rst_period", period, 64'hFFFF);
    chk("rst_pvalid", period_valid, 64'd0);
`ifdef QDEC_INDEX_EN
    chk("rst_index_pos", index_pos, 64'd0);
    chk("rst_index_seen", index_seen, 64'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // x4 full up cycle, 20 clk per level
    move_timed(2'b10);
    move_timed(2'b11);
    move_timed(2'b01);
    move_timed(2'b00);
    chk("x4_up_counter", counter, 64'd4);
    chk("x4_up_dir", dir, 64'd1);
    chk("x4_up_period", period, 64'd20);
    chk("x4_up_pvalid", period_valid, 64'd1);

    // Reverse from zero wraps below zero
    pulse_clear();
    chk("clear_counter", counter, 64'd0);
    move(2'b01, 20);
    move(2'b11, 20);
    move(2'b10, 20);
    move(2'b00, 20);
    chk("x4_dn_counter", counter, 64'hFFFFFC);
    chk("x4_dn_dir", dir, 64'd0);

    // Glitch: A high for 3 clk is rejected
    pulse_clear();
    A = 1'b1;
    repeat (3) @(negedge clk);
    A = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (step === 1'b1) pulses++;
    end
    chk("glitch_steps", 64'(pulses), 64'd0);
    chk("glitch_counter", counter, 64'd0);
    chk("glitch_err", err, 64'd0);
    // A high for 4 clk is accepted (and the return to low counts back)
    A = 1'b1;
    repeat (4) @(negedge clk);
    A = 1'b0;
    repeat (5) @(negedge clk);
    chk("accept4_counter", counter, 64'd1);
    repeat (20) @(negedge clk);
    chk("accept4_back", counter, 64'd0);
    model_dir = 1'b0;

    // Illegal transitions and err_clr
    move(2'b11, 20);
    chk("illegal_err", err, 64'd1);
    chk("illegal_counter", counter, 64'd0);
    move(2'b00, 20);
    pulse_err_clr();
    chk("err_clr", err, 64'd0);
    set_pins(2'b11);
    repeat (LAT) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    chk("illegal_wins", err, 64'd1);
    err_clr = 1'b0;
    repeat (12) @(negedge clk);
    chk("illegal_sticky", err, 64'd1);
    move(2'b00, 20);
    pulse_err_clr();
    chk("err_clr2", err, 64'd0);

    // Modes
    pulse_clear();
    mode = 2'b01;
    move(2'b10, 20); move(2'b11, 20); move(2'b01, 20); move(2'b00, 20);
    chk("x2_counter", counter, 64'd2);
    mode = 2'b10;
    pulse_clear();
    move(2'b10, 20); move(2'b11, 20); move(2'b01, 20); move(2'b00, 20);
    chk("x1_up_counter", counter, 64'd1);
    move(2'b01, 20); move(2'b11, 20); move(2'b10, 20); move(2'b00, 20);
    chk("x1_dn_counter", counter, 64'd0);
    chk("x1_dn_dir", dir, 64'd0);

    // Clear coincident with a step
    mode = 2'b00;
    set_pins(2'b10);
    repeat (LAT) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_cnt = '0;
    chk("clr_step_counter", counter, 64'd0);
    chk("clr_step_step", step, 64'd1);
    chk("clr_step_dir", dir, 64'd1);
    repeat (20) @(negedge clk);

    // Period: steps 100 clk apart, then standstill
    move(2'b11, 100);
    move(2'b01, 100);
    chk("period_100", period, 64'd100);
    chk("period_valid", period_valid, 64'd1);
    move(2'b00, 37);
    chk("period_100b", period, 64'd100);
    repeat (1 << PW) @(negedge clk);
    chk("period_stall", period, 64'hFFFF);
    chk("period_valid_stall", period_valid, 64'd1);

    // Random walk against the model
    pulse_err_clr();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       nab = model_ab ^ 2'b11;
        1, 2, 3, 4: nab = (model_ab == 2'b00) ? 2'b10 : (model_ab == 2'b10) ? 2'b11 :
                          (model_ab == 2'b11) ? 2'b01 : 2'b00;
        default: nab = (model_ab == 2'b00) ? 2'b01 : (model_ab == 2'b01) ? 2'b11 :
                       (model_ab == 2'b11) ? 2'b10 : 2'b00;
      endcase
      move(nab, int'($urandom_range(10, 40)));
      chk("rnd_counter", counter, 64'(model_cnt));
      chk("rnd_dir", dir, 64'(model_dir));
      chk("rnd_err", err, 64'(model_err));
    end

`ifdef QDEC_INDEX_EN
    // Index latch at counter = 37
    mode = 2'b00;
    pulse_clear();
    for (int k = 0; k < 37; k++) begin
      nab = (model_ab == 2'b00) ? 2'b10 : (model_ab == 2'b10) ? 2'b11 :
            (model_ab == 2'b11) ? 2'b01 : 2'b00;
      move(nab, 12);
    end
    chk("idx_counter", counter, 64'd37);
    index = 1'b1;
    repeat (20) @(negedge clk);
    index = 1'b0;
    chk("index_pos", index_pos, 64'd37);
    chk("index_seen", index_seen, 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
